// File: rtl/cp0_unit.sv
// Coprocessor-0 for the P7 pipelined MIPS core: the SR, Cause, EPC and PRId registers,
// the interrupt/exception request to fetch, and the return address for eret.
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h2021_0701
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] din,
    input  logic [31:0] pc_in,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic [31:0] dout,
    output logic [31:0] epc_out,
    output logic        int_req
);

    localparam logic [4:0]  ADDR_SR    = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE = 5'd13;
    localparam logic [4:0]  ADDR_EPC   = 5'd14;
    localparam logic [4:0]  ADDR_PRID  = 5'd15;
    localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

    // SR fields
    logic [5:0]  im_reg;
    logic        exl_reg;
    logic        ie_reg;
    // Cause fields
    logic        bd_reg;
    logic [5:0]  ip_reg;
    logic [4:0]  exc_code_reg;
    // EPC, low two bits always zero
    logic [31:0] epc_reg;

    logic        irq;
    logic        exc;
    logic        mtc0_en;
    logic        wr_sr;
    logic        wr_epc;
    logic [31:0] victim_pc;
    logic [31:0] din_word;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    always_comb begin
        irq = (|(hw_int & im_reg)) & ie_reg & ~exl_reg;
        exc = (exc_code_in != 5'd0) & ~exl_reg;
        // A reset cycle never launches an exception entry into fetch.
        int_req = (irq | exc) & ~reset;
    end

    // Entry suppresses any mtc0 issued in the same cycle.
    always_comb begin
        mtc0_en   = we & ~int_req;
        wr_sr     = mtc0_en & (cp0_addr == ADDR_SR);
        wr_epc    = mtc0_en & (cp0_addr == ADDR_EPC);
        victim_pc = (bd_in ? (pc_in - 32'd4) : pc_in) & WORD_MASK;
        din_word  = din & WORD_MASK;
    end

    always_comb begin
        sr_val    = {16'b0, im_reg, 8'b0, exl_reg, ie_reg};
        cause_val = {bd_reg, 15'b0, ip_reg, 3'b0, exc_code_reg, 2'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_reg       <= 6'd0;
            exl_reg      <= 1'b0;
            ie_reg       <= 1'b0;
            bd_reg       <= 1'b0;
            ip_reg       <= 6'd0;
            exc_code_reg <= 5'd0;
            epc_reg      <= 32'd0;
        end else begin
            // Pending lines stay visible in IP even while a handler runs.
            ip_reg <= hw_int;

            if (int_req) begin
                exl_reg      <= 1'b1;
                bd_reg       <= bd_in;
                exc_code_reg <= irq ? 5'd0 : exc_code_in;
                epc_reg      <= victim_pc;
            end else begin
                if (wr_sr) begin
                    im_reg <= din[15:10];
                    ie_reg <= din[0];
                end
                // eret clears EXL even when din[1] says otherwise.
                if (eret)
                    exl_reg <= 1'b0;
                else if (wr_sr)
                    exl_reg <= din[1];
                if (wr_epc)
                    epc_reg <= din_word;
            end
        end
    end

    always_comb begin
        dout = 32'd0;
        case (cp0_addr)
            ADDR_SR:    dout = sr_val;
            ADDR_CAUSE: dout = cause_val;
            ADDR_EPC:   dout = epc_reg;
            ADDR_PRID:  dout = PRID;
            default:    dout = 32'd0;
        endcase
    end

    // Forward a same-cycle EPC write so an eret right behind it returns to the new address.
    always_comb begin
        epc_out = wr_epc ? din_word : epc_reg;
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed-vector bench for cp0_unit; expected values worked out by hand from the register map.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  cp0_addr;
    logic [31:0] din;
    logic [31:0] pc_in;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic [31:0] dout;
    logic [31:0] epc_out;
    logic        int_req;

    int total = 0;
    int bad   = 0;

    cp0_unit dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .cp0_addr    (cp0_addr),
        .din         (din),
        .pc_in       (pc_in),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .hw_int      (hw_int),
        .eret        (eret),
        .dout        (dout),
        .epc_out     (epc_out),
        .int_req     (int_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        cp0_addr = addr;
        #1;
        check(tag, dout, exp);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        we = 1'b1; cp0_addr = addr; din = data;
        step();
        we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; cp0_addr = 5'd0; din = 32'd0; pc_in = 32'd0;
        bd_in = 1'b0; exc_code_in = 5'd0; hw_int = 6'd0; eret = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        check("rst_int_req", {31'd0, int_req}, 32'd0);
        check("rst_epc_out", epc_out, 32'd0);
        rd("rst_sr", 5'd12, 32'd0);
        rd("rst_cause", 5'd13, 32'd0);
        rd("rst_epc", 5'd14, 32'd0);

        // Hardware interrupt entry
        mtc0(5'd12, 32'h0000_0401);
        rd("sr_write", 5'd12, 32'h0000_0401);
        hw_int = 6'b000001; pc_in = 32'h3010; bd_in = 1'b0;
        #1;
        check("irq_req", {31'd0, int_req}, 32'd1);
        step();
        check("irq_after_req", {31'd0, int_req}, 32'd0);
        rd("irq_epc", 5'd14, 32'h0000_3010);
        rd("irq_cause", 5'd13, 32'h0000_0400);
        rd("irq_sr", 5'd12, 32'h0000_0403);

        // EPC write inside handler, forwarded to epc_out, then eret
        we = 1'b1; cp0_addr = 5'd14; din = 32'h0000_3047;
        #1;
        check("fwd_epc_out", epc_out, 32'h0000_3044);
        check("fwd_no_writethru", dout, 32'h0000_3010);
        step();
        we = 1'b0; eret = 1'b1;
        #1;
        check("eret_epc_out", epc_out, 32'h0000_3044);
        check("eret_cycle_req", {31'd0, int_req}, 32'd0);
        step();
        eret = 1'b0;
        rd("post_eret_sr", 5'd12, 32'h0000_0401);
        check("reassert_req", {31'd0, int_req}, 32'd1);
        pc_in = 32'h3100;
        step();
        hw_int = 6'd0;
        rd("reentry_epc", 5'd14, 32'h0000_3100);

        // eret beats din[1] on a simultaneous SR write
        we = 1'b1; cp0_addr = 5'd12; din = 32'h0000_0403; eret = 1'b1;
        step();
        we = 1'b0; eret = 1'b0;
        rd("eret_mtc0_sr", 5'd12, 32'h0000_0401);

        // Interrupt outranks exception; mtc0 suppressed during entry
        hw_int = 6'b000001; exc_code_in = 5'd4; pc_in = 32'h3200; bd_in = 1'b0;
        we = 1'b1; cp0_addr = 5'd14; din = 32'hDEAD_0000;
        #1;
        check("prio_req", {31'd0, int_req}, 32'd1);
        check("prio_epc_out", epc_out, 32'h0000_3100);
        step();
        we = 1'b0;
        rd("prio_cause", 5'd13, 32'h0000_0400);
        rd("prio_epc", 5'd14, 32'h0000_3200);
        hw_int = 6'd0; exc_code_in = 5'd0; eret = 1'b1;
        step();
        eret = 1'b0;

        // Exception in a delay slot
        mtc0(5'd12, 32'h0000_0001);
        exc_code_in = 5'd12; pc_in = 32'h3024; bd_in = 1'b1;
        #1;
        check("exc_req", {31'd0, int_req}, 32'd1);
        step();
        exc_code_in = 5'd0; bd_in = 1'b0;
        rd("exc_epc", 5'd14, 32'h0000_3020);
        rd("exc_cause", 5'd13, 32'h8000_0030);
        rd("exc_sr", 5'd12, 32'h0000_0003);

        // Nesting blocked while EXL is set
        exc_code_in = 5'd5; hw_int = 6'h3F;
        #1;
        check("nest_req", {31'd0, int_req}, 32'd0);
        step();
        rd("nest_cause", 5'd13, 32'h8000_FC30);
        rd("nest_epc", 5'd14, 32'h0000_3020);

        // Read-only / unmapped addresses
        mtc0(5'd13, 32'hFFFF_FFFF);
        mtc0(5'd15, 32'hFFFF_FFFF);
        rd("cause_ro", 5'd13, 32'h8000_FC30);
        rd("prid", 5'd15, 32'h2021_0701);
        rd("unmapped", 5'd3, 32'h0000_0000);

        // Reset mid-handler
        exc_code_in = 5'd0;
        reset = 1'b1;
        #1;
        check("rst_cycle_req", {31'd0, int_req}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, int_req}, 32'd0);
        check("mid_rst_epc_out", epc_out, 32'd0);
        rd("mid_rst_sr", 5'd12, 32'd0);
        rd("mid_rst_cause", 5'd13, 32'd0);
        rd("mid_rst_epc", 5'd14, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
